// File: rtl/video_in_window_scaler.sv
// video_in_window_scaler
// Crops a DE/HS/VS pixel stream to an H_ACT x V_ACT window and emits it as
// bypass, 2x2 rounded box average, or 2:1 decimation. Output latency is a
// fixed two clocks in every mode. The mode is latched only on a vs_in rising
// edge, so a frame is never split between two modes.
module video_in_window_scaler #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 720,
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int HW    = 12
) (
  input  logic             pixclk_in,
  input  logic             rst,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             de_in,
  input  logic [CH*DW-1:0] pix_in,
  input  logic [1:0]       mode_in,
  output logic             vs_out,
  output logic             hs_out,
  output logic             de_out,
  output logic [CH*DW-1:0] pix_out,
  output logic [15:0]      frame_cnt,
  output logic             line_err
);

  localparam int NB = H_ACT / 2;
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = DW + 1;
  localparam logic [HW-1:0] CNT_MAX = '1;
  localparam logic [HW-1:0] H_LIM   = HW'(H_ACT);
  localparam logic [HW-1:0] V_LIM   = HW'(V_ACT);

  typedef enum logic [1:0] {
    M_BYPASS = 2'd0,
    M_AVG    = 2'd1,
    M_DEC    = 2'd2
  } mode_t;

  logic             vs_d1, hs_d1, de_d1;
  logic [1:0]       mode_s1, mode_s2;
  mode_t            mode_act;
  logic             frame_ok;
  logic [HW-1:0]    h_cnt, v_cnt;
  logic             vs_rise, de_fall, in_win, h_odd, v_odd;
  logic [AW-1:0]    addr;
  logic [CH*DW-1:0] prev_q;
  logic [CH*SW-1:0] hsum;
  logic [CH*SW-1:0] rd_q;
  logic [CH*DW-1:0] avg;
  logic             s1_valid, s1_valid_d;
  logic [CH*DW-1:0] s1_pix, s1_pix_d;
  logic [CH*SW-1:0] lbuf [NB];

  assign vs_rise = vs_in & ~vs_d1;
  assign de_fall = de_d1 & ~de_in;
  // frame_ok keeps the window closed between reset and the first vs rise
  assign in_win  = frame_ok & de_in & (h_cnt < H_LIM) & (v_cnt < V_LIM);
  assign h_odd   = h_cnt[0];
  assign v_odd   = v_cnt[0];
  assign addr    = h_cnt[AW:1];

  // Per-channel horizontal pair sum and rounded 2x2 average
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [SW-1:0]   hsum_c;
    logic [DW+1:0]   tot_c;
    assign hsum_c = SW'(prev_q[c*DW +: DW]) + SW'(pix_in[c*DW +: DW]);
    assign tot_c  = (DW+2)'(hsum_c) + (DW+2)'(rd_q[c*SW +: SW]) + (DW+2)'(2);
    assign hsum[c*SW +: SW] = hsum_c;
    assign avg[c*DW +: DW]  = DW'(tot_c >> 2);
  end

  // Select what the first pipeline stage captures for the active mode
  always_comb begin
    s1_valid_d = 1'b0;
    s1_pix_d   = pix_in;
    unique case (mode_act)
      M_AVG: begin
        s1_valid_d = in_win & h_odd & v_odd;
        s1_pix_d   = avg;
      end
      M_DEC:   s1_valid_d = in_win & ~h_odd & ~v_odd;
      default: s1_valid_d = in_win;
    endcase
  end

  // Sync delays, mode latch, window counters and the two-stage output pipe
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      vs_d1     <= 1'b0;
      hs_d1     <= 1'b0;
      de_d1     <= 1'b0;
      vs_out    <= 1'b0;
      hs_out    <= 1'b0;
      mode_s1   <= 2'd0;
      mode_s2   <= 2'd0;
      mode_act  <= M_BYPASS;
      frame_ok  <= 1'b0;
      frame_cnt <= 16'd0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_err  <= 1'b0;
      prev_q    <= '0;
      s1_valid  <= 1'b0;
      s1_pix    <= '0;
      de_out    <= 1'b0;
      pix_out   <= '0;
    end else begin
      vs_d1   <= vs_in;
      hs_d1   <= hs_in;
      de_d1   <= de_in;
      vs_out  <= vs_d1;
      hs_out  <= hs_d1;
      mode_s1 <= mode_in;
      mode_s2 <= mode_s1;

      if (vs_rise) begin
        mode_act  <= (mode_s2 == 2'd3) ? M_BYPASS : mode_t'(mode_s2);
        frame_ok  <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (!de_in)                h_cnt <= '0;
      else if (h_cnt != CNT_MAX) h_cnt <= h_cnt + HW'(1);

      // a vs rise wins over a simultaneous de fall
      if (vs_rise)                           v_cnt <= '0;
      else if (de_fall && v_cnt != CNT_MAX)  v_cnt <= v_cnt + HW'(1);

      line_err <= de_in & (h_cnt == H_LIM);

      if (in_win && !h_odd) prev_q <= pix_in;

      s1_valid <= s1_valid_d;
      s1_pix   <= s1_pix_d;
      de_out   <= s1_valid;
      pix_out  <= s1_valid ? s1_pix : '0;
    end
  end

  // Line buffer: even lines write pair sums, reads issue on the even pixel
  always_ff @(posedge pixclk_in) begin
    if (in_win && h_odd && !v_odd && mode_act == M_AVG) lbuf[addr] <= hsum;
    if (in_win && !h_odd) rd_q <= lbuf[addr];
  end

endmodule

// File: tb/tb_video_in_window_scaler.sv
// Scoreboard bench for video_in_window_scaler (8x4 window, 10x12 frames).
module tb_video_in_window_scaler;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int DW    = 8;
  localparam int CH    = 3;
  localparam int HW    = 12;
  localparam int PW    = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          vs_in, hs_in, de_in;
  logic [PW-1:0] pix_in;
  logic [1:0]    mode_in;
  logic          vs_out, hs_out, de_out, line_err;
  logic [PW-1:0] pix_out;
  logic [15:0]   frame_cnt;

  video_in_window_scaler #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .DW(DW), .CH(CH), .HW(HW)
  ) dut (
    .pixclk_in(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .pix_in(pix_in), .mode_in(mode_in), .vs_out(vs_out), .hs_out(hs_out),
    .de_out(de_out), .pix_out(pix_out), .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pix;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          le_cnt = 0;
  bit          rst_pend = 0;
  logic [1:0]  sh_vs = '0, sh_hs = '0;

  bit          mdl_ok = 0;
  int          mdl_mode = 0;
  logic [15:0] mdl_fc = '0;
  logic [PW-1:0] m_prev = '0;
  int          m_lbuf [H_ACT/2][CH];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      rst_pend = 1;
    end else if (rst_pend) begin
      rst_pend = 0;
      check_val("reset_outs", {de_out, pix_out, vs_out, hs_out, line_err, frame_cnt}, 64'd0);
      sb.delete();
      le_cnt = 0;
      sh_vs = {1'b0, vs_in};
      sh_hs = {1'b0, hs_in};
    end else begin
      check_val("vs_out", vs_out, sh_vs[1]);
      check_val("hs_out", hs_out, sh_hs[1]);
      if (line_err) le_cnt++;
      if (de_out) begin
        if (sb.size() == 0) begin
          check_val("extra_de_out", de_out, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("pix", pix_out, e.pix);
          check_val("latency", cyc, e.cyc);
        end
      end else begin
        check_val("pix_idle", pix_out, 0);
      end
      sh_vs = {sh_vs[0], vs_in};
      sh_hs = {sh_hs[0], hs_in};
    end
  end

  task automatic step(input logic v_s, input logic h_s, input logic d, input logic [PW-1:0] p);
    @(posedge clk);
    #1;
    vs_in  = v_s;
    hs_in  = h_s;
    de_in  = d;
    pix_in = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [PW-1:0] pat_pix(input int pat, input int v, input int h);
    logic [7:0] b;
    case (pat)
      0: return {8'(v), 8'(h), 8'(h)};
      1: begin b = 8'(10 * (h + 1) + v); return {b, b, b}; end
      2: return {PW{1'b1}};
      3: begin b = 8'(h + 16 * v); return {b, b, b}; end
      default: return PW'($urandom);
    endcase
  endfunction

  task automatic mdl_vs_rise();
    mdl_fc   = mdl_fc + 16'd1;
    mdl_mode = (mode_in == 2'd3) ? 0 : int'(mode_in);
    mdl_ok   = 1;
  endtask

  task automatic mdl_push(input int v, input int h, input logic [PW-1:0] p);
    exp_t e;
    e.cyc = cyc + 2;
    e.pix = p;
    if (!mdl_ok || v >= V_ACT || h >= H_ACT) return;
    case (mdl_mode)
      0: sb.push_back(e);
      2: if (v % 2 == 0 && h % 2 == 0) sb.push_back(e);
      default: begin
        if (h % 2 == 0) begin
          m_prev = p;
        end else if (v % 2 == 0) begin
          for (int c = 0; c < CH; c++)
            m_lbuf[h/2][c] = int'(m_prev[c*DW +: DW]) + int'(p[c*DW +: DW]);
        end else begin
          for (int c = 0; c < CH; c++)
            e.pix[c*DW +: DW] = 8'((int'(m_prev[c*DW +: DW]) + int'(p[c*DW +: DW])
                                    + m_lbuf[h/2][c] + 2) / 4);
          sb.push_back(e);
        end
      end
    endcase
  endtask

  task automatic drive_line(input int vl, input int pat, input bit vs_end, input int rst_h);
    logic [PW-1:0] p;
    step(1'b0, 1'b1, 1'b0, '0);
    idle(2);
    for (int h = 0; h < 12; h++) begin
      p = pat_pix(pat, vl, h);
      step(1'b0, 1'b0, 1'b1, p);
      if (h == rst_h) begin
        rst      = 1'b1;
        mdl_ok   = 0;
        mdl_mode = 0;
        mdl_fc   = '0;
      end else begin
        rst = 1'b0;
      end
      mdl_push(vl, h, p);
    end
    step(vs_end, 1'b0, 1'b0, '0);
    rst = 1'b0;
    if (vs_end) mdl_vs_rise();
    step(vs_end, 1'b0, 1'b0, '0);
    step(vs_end, 1'b0, 1'b0, '0);
    if (vs_end) idle(2);
  endtask

  task automatic drive_frame(input int nl, input int pat, input int tog_v,
                             input int rst_v, input int vsc_v, input bit chk_le);
    int vl;
    le_cnt = 0;
    step(1'b1, 1'b0, 1'b0, '0);
    mdl_vs_rise();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(2);
    vl = 0;
    for (int i = 0; i < nl; i++) begin
      if (i == tog_v) mode_in = 2'd1;
      drive_line(vl, pat, i == vsc_v, (i == rst_v) ? 5 : -1);
      vl = (i == vsc_v) ? 0 : vl + 1;
    end
    idle(4);
    check_val("frame_cnt", frame_cnt, mdl_fc);
    if (chk_le) check_val("line_err_cnt", le_cnt, nl);
    check_val("sb_drain", sb.size(), 0);
  endtask

  initial begin
    for (int a = 0; a < H_ACT/2; a++)
      for (int c = 0; c < CH; c++) m_lbuf[a][c] = 0;
    rst = 1'b1;
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; pix_in = '0; mode_in = 2'd0;
    idle(3);
    rst = 1'b0;
    idle(4);

    drive_frame(10, 0, -1, -1, -1, 1);          // bypass {v,h,h}
    mode_in = 2'd1; idle(4);
    drive_frame(10, 1, -1, -1, -1, 1);          // average, first output 16
    drive_frame(10, 2, -1, -1, -1, 1);          // average of all-255 stays 255
    mode_in = 2'd2; idle(4);
    drive_frame(10, 3, -1, -1, -1, 1);          // decimate h+16v
    mode_in = 2'd0; idle(4);
    drive_frame(10, 4, 3, -1, -1, 1);           // toggle to 1 mid-frame: still bypass
    drive_frame(10, 4, -1, -1, -1, 1);          // now averaged
    mode_in = 2'd3; idle(4);
    drive_frame(6, 4, -1, -1, -1, 1);           // reserved behaves as bypass
    mode_in = 2'd1; idle(4);
    drive_frame(10, 1, -1, 1, -1, 0);           // reset mid-line in mode 1
    drive_frame(10, 1, -1, -1, -1, 1);          // mode re-latched after reset
    mode_in = 2'd2; idle(4);
    drive_frame(10, 3, -1, -1, 2, 1);           // vs rise coincident with de fall
    idle(4);
    check_val("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
